mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 30 +++
 rtl/mult_div_unit_if.sv | 23 ++
 rtl/mult_div_unit_div_step.sv | 24 ++
 rtl/mult_div_unit.sv | 101 ++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, widths and
// small sign-handling helpers used by the top level.
package mult_div_unit_pkg;

  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;
  localparam int DIV_ITER = 32;
  localparam int CNT_W    = 6;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] CALC = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } div_result_t;

  function automatic logic [DATA_W-1:0] negate_if(input logic [DATA_W-1:0] v,
                                                   input logic neg);
    return neg ? (~v + {{(DATA_W-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Magnitude of a value that is only treated as negative for signed ops.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic is_signed);
    return negate_if(v, is_signed & v[DATA_W-1]);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the pipeline and the divide unit.
interface mult_div_unit_if;

  logic                                      start_i;
  logic                                      signed_i;
  logic [mult_div_unit_pkg::DATA_W-1:0]      a_i;
  logic [mult_div_unit_pkg::DATA_W-1:0]      b_i;
  logic                                      annul_i;
  logic                                      stall_o;
  logic                                      ready_o;
  logic [mult_div_unit_pkg::RESULT_W-1:0]    result_o;

  modport master (
    output start_i, signed_i, a_i, b_i, annul_i,
    input  stall_o, ready_o, result_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, annul_i,
    output stall_o, ready_o, result_o
  );

endinterface

// File: rtl/mult_div_unit_div_step.sv
// One combinational radix-2 restoring division iteration on unsigned
// magnitudes; the partial remainder is always kept below the divisor.
module div_step
  import mult_div_unit_pkg::*;
(
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = {1'b0, shifted[DATA_W-1:0]} - {1'b0, divisor};

  // A set top bit means shifted exceeds 2^32 > divisor, so the subtraction
  // is always kept; the low 32 bits of diff are still the exact remainder.
  assign q_bit   = shifted[DATA_W] | ~diff[DATA_W];
  assign rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle DIV/DIVU unit: 32 restoring iterations on magnitudes, with
// sign fixup applied as the result is captured on entry to DONE.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            resetn,
  mult_div_unit_if.slave  bus
);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] divisor;
  logic              sign_a;
  logic              sign_b;
  logic              op_signed;
  div_result_t       result;

  logic              accept;
  logic              last_iter;
  logic              div_zero;
  logic [DATA_W-1:0] step_rem;
  logic              step_q;
  logic [DATA_W-1:0] raw_q;
  logic [DATA_W-1:0] final_q;
  logic [DATA_W-1:0] final_r;

  assign accept    = (state == IDLE) & bus.start_i & ~bus.annul_i;
  assign div_zero  = (bus.b_i == '0);
  assign last_iter = (cnt == CNT_W'(DIV_ITER - 1));

  div_step u_div_step (
    .rem_in       (rem),
    .dividend_bit (quo[DATA_W-1]),
    .divisor      (divisor),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  // The dividend shifts out of quo's top while quotient bits shift in below.
  assign raw_q   = {quo[DATA_W-2:0], step_q};
  assign final_q = negate_if(raw_q, op_signed & (sign_a ^ sign_b));
  assign final_r = negate_if(step_rem, op_signed & sign_a);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = div_zero ? DONE : CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.annul_i) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      divisor   <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      op_signed <= 1'b0;
      result    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        cnt       <= '0;
        rem       <= '0;
        quo       <= magnitude(bus.a_i, bus.signed_i);
        divisor   <= magnitude(bus.b_i, bus.signed_i);
        sign_a    <= bus.a_i[DATA_W-1];
        sign_b    <= bus.b_i[DATA_W-1];
        op_signed <= bus.signed_i;
        if (div_zero) begin
          result.hi <= bus.a_i;
          result.lo <= '1;
        end
      end else if ((state == CALC) && !bus.annul_i) begin
        cnt <= cnt + CNT_W'(1);
        rem <= step_rem;
        quo <= raw_q;
        if (last_iter) begin
          result.hi <= final_r;
          result.lo <= final_q;
        end
      end
    end
  end

  // Outputs are gated by reset so they drop before any clock edge.
  assign bus.stall_o  = resetn & (accept | ((state == CALC) & ~bus.annul_i));
  assign bus.ready_o  = resetn & (state == DONE) & ~bus.annul_i;
  assign bus.result_o = result;

endmodule
